snake_head_mover: RTL and testbench
===================================

# snake_head_mover

Moves the snake across the play grid, one step per move period. It consumes the one-hot `direction` output of the key-to-direction stage and keeps the snake's head and body segment positions in registers. On each move it checks for wall and self-collision. It exposes segment coordinates through an indexed read port for the VGA renderer.

## Interface
- `GRID_W`, default 32: grid columns; x range 0..GRID_W-1.
- `GRID_H`, default 24: grid rows; y range 0..GRID_H-1; y increases downward.
- `MAX_LEN`, default 16: maximum number of segments (head included).
- `START_LEN`, default 3: length after reset; must satisfy 1 ≤ START_LEN ≤ MAX_LEN and START_LEN-1 ≤ START_X.
- `START_X`, default 16: head x after reset.
- `START_Y`, default 12: head y after reset.
- `TICKS_PER_MOVE`, default 5_000_000: clock cycles per move; must be ≥ 2.
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `direction` in 4: from the direction stage. 1111 = none, 0001 = down, 0010 = up, 0100 = right, 1000 = left.
- `grow` in 1: single-cycle pulse requesting one extra segment.
- `seg_index` in clog2(MAX_LEN): renderer read address; index 0 = head.
- `seg_x` out clog2(GRID_W): x of segment `seg_index`, combinational from the registers.
- `seg_y` out clog2(GRID_H): y of segment `seg_index`, combinational from the registers.
- `head_x` out clog2(GRID_W): current head x; equals segment 0.
- `head_y` out clog2(GRID_H): current head y.
- `length` out clog2(MAX_LEN+1): current segment count.
- `move_tick` out 1: one-cycle pulse on the cycle a move becomes visible.
- `game_over` out 1: high while in DEAD.

## Operation
- State machine: IDLE, RUN, DEAD.
- Reset values (when `reset`=0 at a clock edge):
  - state IDLE; `length` = START_LEN.
  - seg[i] = (START_X-i, START_Y) for i < START_LEN; seg[i] = (0,0) otherwise.
  - move timer = 0; `move_tick` = 0; `game_over` = 0.
  - grow_pending = 0; last_dir = 0100 (right).
- IDLE:
  - Timer held at 0; no motion.
  - Leave for RUN when `direction` is exactly one of 0001/0010/0100/1000; latch it into last_dir.
  - 1111 and any other value keep the block in IDLE.
- RUN:
  - Timer counts 0..TICKS_PER_MOVE-1 and wraps; a move executes on the edge where timer = TICKS_PER_MOVE-1.
  - Any cycle with a valid one-hot `direction` updates last_dir. Other values (including 1111) leave last_dir unchanged, so the snake keeps moving.
  - This block does not filter reversals; that is the direction stage's job. A reversal is treated as a normal move and self-collides.
- Move computation:
  - next head = head + last_dir step: down y+1, up y-1, right x+1, left x-1.
  - Computed at full width plus one bit, so underflow below 0 is detected, not wrapped.
- Wall collision: next x < 0 or ≥ GRID_W, or next y < 0 or ≥ GRID_H → DEAD.
- Self-collision: next head equals seg[i] for any 1 ≤ i ≤ length-2 → DEAD. Also counts seg[length-1] when a grow will be consumed by this move.
- On any collision, no segment or length update occurs.
- Normal move:
  - seg[i] ← seg[i-1] for i = 1..MAX_LEN-1; seg[0] ← next head.
  - If grow_pending and length < MAX_LEN: length += 1.
  - grow_pending is cleared on every executed move, whether or not length grew.
- `grow` sets grow_pending in any state. Multiple pulses between moves collapse into one.
- DEAD: all registers frozen; `game_over` = 1; only reset leaves DEAD.
- Read port: `seg_index` ≥ `length` returns the stored, stale register value; the renderer must mask by `length`.

## Timing
- Move edge: segments, length, `move_tick`=1 and `game_over` (on collision) all become visible the cycle after the move edge. `move_tick` lasts exactly one cycle.
- First move occurs TICKS_PER_MOVE edges after the IDLE→RUN edge; thereafter moves are every TICKS_PER_MOVE cycles.
- `direction` is sampled at the move edge itself. A direction change at that edge takes effect on that move.
- `grow` arriving on the move edge is consumed by that move.
- `grow` arriving one cycle later waits for the next move.
- Reset has priority over all events, including a move edge or collision on the same cycle.
- `move_tick` is 0 in the cycle after reset.

## Test plan
Bench overrides: GRID_W=GRID_H=8, START=(4,4), START_LEN=3, MAX_LEN=4, TICKS_PER_MOVE=4.

- Hold `direction`=1111 for 20 cycles after reset → head (4,4), `length`=3, seg1=(3,4), seg2=(2,4), `move_tick` never high.
- Drive 0100, then 1111 → move_tick every 4 cycles; head x = 5, 6, 7; the 4th move sets `game_over`=1 with head held at (7,4); further cycles produce no change.
- Drive 0100, then pulse `grow` twice before the first move → `length`=4 after move 1 with seg3=(2,4). Another `grow` → `length` stays 4 (MAX_LEN).
- From IDLE drive 1000 → first move targets (3,4)=seg1, so `game_over`=1 and head stays (4,4). Check that heading 0010 at (4,0) into y=-1 also gives `game_over`.
- Run right, then present 0011, 1111 and 0001 on the move edge → the invalid values continue right; 0001 moves down on that same move.
- Assert `reset`=0 mid-RUN and again in DEAD → next cycle matches the reset values exactly; `game_over`=0, state IDLE.

Source files
------------

// File: rtl/snake_head_mover.sv
// rtl/snake_head_mover.sv - snake head/body position registers, move timer and collision FSM
// Segment 0 is the head; the body shifts one slot per executed move.
module snake_head_mover #(
   parameter int GRID_W         = 32,
   parameter int GRID_H         = 24,
   parameter int MAX_LEN        = 16,
   parameter int START_LEN      = 3,
   parameter int START_X        = 16,
   parameter int START_Y        = 12,
   parameter int TICKS_PER_MOVE = 5_000_000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [3:0]                   direction,
   input  logic                         grow,
   input  logic [$clog2(MAX_LEN)-1:0]   seg_index,
   output logic [$clog2(GRID_W)-1:0]    seg_x,
   output logic [$clog2(GRID_H)-1:0]    seg_y,
   output logic [$clog2(GRID_W)-1:0]    head_x,
   output logic [$clog2(GRID_H)-1:0]    head_y,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic                         move_tick,
   output logic                         game_over
);

   localparam int XW    = $clog2(GRID_W);
   localparam int YW    = $clog2(GRID_H);
   localparam int IW    = $clog2(MAX_LEN);
   localparam int LW    = $clog2(MAX_LEN + 1);
   localparam int TW    = $clog2(TICKS_PER_MOVE);
   localparam int DEPTH = 1 << IW;

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   state_t          state, state_d;
   logic [XW-1:0]   seg_xs [DEPTH];
   logic [YW-1:0]   seg_ys [DEPTH];
   logic [TW-1:0]   timer;
   logic [3:0]      last_dir;
   logic            grow_pending;

   logic            dir_valid, move_edge, wall, self_hit, collide, grow_take;
   logic [3:0]      step_dir;
   logic [XW:0]     nx;
   logic [YW:0]     ny;

   assign seg_x     = seg_xs[seg_index];
   assign seg_y     = seg_ys[seg_index];
   assign head_x    = seg_xs[0];
   assign head_y    = seg_ys[0];
   assign game_over = (state == DEAD);

   // Extra headroom bit: 0-1 wraps to all ones, which the >= GRID compare flags as a wall.
   always_comb begin
      dir_valid = (direction == 4'b0001) || (direction == 4'b0010) ||
                  (direction == 4'b0100) || (direction == 4'b1000);
      step_dir  = dir_valid ? direction : last_dir;
      move_edge = (state == RUN) && (timer == TW'(TICKS_PER_MOVE - 1));
      nx = {1'b0, seg_xs[0]};
      ny = {1'b0, seg_ys[0]};
      case (step_dir)
         4'b0001: ny = ny + 1'b1;
         4'b0010: ny = ny - 1'b1;
         4'b0100: nx = nx + 1'b1;
         4'b1000: nx = nx - 1'b1;
         default: ;
      endcase
      wall      = (nx >= (XW+1)'(GRID_W)) || (ny >= (YW+1)'(GRID_H));
      grow_take = (grow_pending || grow) && (length < LW'(MAX_LEN));
      self_hit  = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((nx[XW-1:0] == seg_xs[i]) && (ny[YW-1:0] == seg_ys[i]) &&
             ((i <= int'(length) - 2) || (grow_take && (i == int'(length) - 1))))
            self_hit = 1'b1;
      end
      collide = wall || self_hit;
      state_d = state;
      case (state)
         IDLE:    if (dir_valid) state_d = RUN;
         RUN:     if (move_edge && collide) state_d = DEAD;
         default: state_d = state;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         length       <= LW'(START_LEN);
         timer        <= '0;
         move_tick    <= 1'b0;
         grow_pending <= 1'b0;
         last_dir     <= 4'b0100;
         for (int i = 0; i < DEPTH; i++) begin
            seg_xs[i] <= (i < START_LEN) ? XW'(START_X - i) : '0;
            seg_ys[i] <= (i < START_LEN) ? YW'(START_Y) : '0;
         end
      end else begin
         state     <= state_d;
         move_tick <= 1'b0;
         if (move_edge && !collide)
            grow_pending <= 1'b0;
         else if (grow)
            grow_pending <= 1'b1;
         case (state)
            IDLE: begin
               timer <= '0;
               if (dir_valid) last_dir <= direction;
            end
            RUN: begin
               if (dir_valid) last_dir <= direction;
               timer <= move_edge ? '0 : timer + 1'b1;
               if (move_edge) begin
                  move_tick <= 1'b1;
                  if (!collide) begin
                     for (int i = 1; i < MAX_LEN; i++) begin
                        seg_xs[i] <= seg_xs[i-1];
                        seg_ys[i] <= seg_ys[i-1];
                     end
                     seg_xs[0] <= nx[XW-1:0];
                     seg_ys[0] <= ny[YW-1:0];
                     if (grow_take) length <= length + LW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_head_mover.sv
// tb/tb_snake_head_mover.sv - table-driven bench for snake_head_mover on an 8x8 grid
module tb_snake_head_mover;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] direction = 4'b1111;
   logic       grow = 1'b0;
   logic [1:0] seg_index = 2'd0;
   logic [2:0] seg_x, seg_y, head_x, head_y;
   logic [2:0] length;
   logic       move_tick, game_over;

   int tests  = 0;
   int failed = 0;
   int seen   = 0;

   snake_head_mover #(
      .GRID_W(8), .GRID_H(8), .MAX_LEN(4), .START_LEN(3),
      .START_X(4), .START_Y(4), .TICKS_PER_MOVE(4)
   ) dut (
      .clock(clock), .reset(reset), .direction(direction), .grow(grow),
      .seg_index(seg_index), .seg_x(seg_x), .seg_y(seg_y),
      .head_x(head_x), .head_y(head_y), .length(length),
      .move_tick(move_tick), .game_over(game_over)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         rst;
      logic [3:0] dir;
      bit         grw;
      int         cyc;
      int         hx, hy, len, go;
      int         sidx, sx, sy;
      int         ticks;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         if (move_tick) seen++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; direction = 4'b1111; grow = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic check_seg(input string name, input int idx, input int ex, input int ey);
      seg_index = 2'(idx);
      #1;
      check($sformatf("%s seg%0d x", name, idx), seg_x, ex);
      check($sformatf("%s seg%0d y", name, idx), seg_y, ey);
   endtask

   task automatic check_reset_state(input string name);
      check({name, " move_tick"}, move_tick, 0);
      check({name, " game_over"}, game_over, 0);
      check({name, " head_x"}, head_x, 4);
      check({name, " head_y"}, head_y, 4);
      check({name, " length"}, length, 3);
      check_seg(name, 1, 3, 4);
      check_seg(name, 2, 2, 4);
      check_seg(name, 3, 0, 0);
   endtask

   initial begin
      // idle hold
      vecs.push_back('{1, 4'b1111, 0, 20, 4, 4, 3, 0, 1, 3, 4, 0});
      // run right into the wall
      vecs.push_back('{1, 4'b0100, 0, 1, 4, 4, 3, 0, 1, 3, 4, 0});
      vecs.push_back('{0, 4'b1111, 0, 4, 5, 4, 3, 0, 1, 4, 4, 1});
      vecs.push_back('{0, 4'b1111, 0, 4, 6, 4, 3, 0, 1, 5, 4, 1});
      vecs.push_back('{0, 4'b1111, 0, 4, 7, 4, 3, 0, 1, 6, 4, 1});
      vecs.push_back('{0, 4'b1111, 0, 4, 7, 4, 3, 1, 2, 5, 4, -1});
      vecs.push_back('{0, 4'b1111, 0, 8, 7, 4, 3, 1, 1, 6, 4, 0});
      // grow twice before first move, then grow at MAX_LEN
      vecs.push_back('{1, 4'b0100, 1, 1, 4, 4, 3, 0, 1, 3, 4, 0});
      vecs.push_back('{0, 4'b1111, 1, 1, 4, 4, 3, 0, 2, 2, 4, 0});
      vecs.push_back('{0, 4'b1111, 0, 3, 5, 4, 4, 0, 3, 2, 4, 1});
      vecs.push_back('{0, 4'b1111, 1, 4, 6, 4, 4, 0, 3, 3, 4, 1});
      // reversal into seg1
      vecs.push_back('{1, 4'b1000, 0, 1, 4, 4, 3, 0, 1, 3, 4, 0});
      vecs.push_back('{0, 4'b1111, 0, 4, 4, 4, 3, 1, 1, 3, 4, -1});
      // up into y = -1
      vecs.push_back('{1, 4'b0010, 0, 1, 4, 4, 3, 0, 2, 2, 4, 0});
      vecs.push_back('{0, 4'b1111, 0, 16, 4, 0, 3, 0, 1, 4, 1, 4});
      vecs.push_back('{0, 4'b1111, 0, 4, 4, 0, 3, 1, 2, 4, 2, -1});
      // direction presented on the move edge
      vecs.push_back('{1, 4'b0100, 0, 1, 4, 4, 3, 0, 0, 4, 4, 0});
      vecs.push_back('{0, 4'b1111, 0, 3, 4, 4, 3, 0, 1, 3, 4, 0});
      vecs.push_back('{0, 4'b0011, 0, 1, 5, 4, 3, 0, 1, 4, 4, 1});
      vecs.push_back('{0, 4'b1111, 0, 4, 6, 4, 3, 0, 2, 4, 4, 1});
      vecs.push_back('{0, 4'b1111, 0, 3, 6, 4, 3, 0, 1, 5, 4, 0});
      vecs.push_back('{0, 4'b0001, 0, 1, 6, 5, 3, 0, 1, 6, 4, 1});
      vecs.push_back('{0, 4'b1111, 0, 4, 6, 6, 3, 0, 2, 6, 4, 1});

      do_reset();
      check_reset_state("post-reset");

      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset();
         seen = 0;
         direction = vecs[k].dir;
         grow = vecs[k].grw;
         cycles(1);
         grow = 1'b0;
         cycles(vecs[k].cyc - 1);
         check($sformatf("row%0d head_x", k), head_x, vecs[k].hx);
         check($sformatf("row%0d head_y", k), head_y, vecs[k].hy);
         check($sformatf("row%0d length", k), length, vecs[k].len);
         check($sformatf("row%0d game_over", k), game_over, vecs[k].go);
         check_seg($sformatf("row%0d", k), vecs[k].sidx, vecs[k].sx, vecs[k].sy);
         if (vecs[k].ticks >= 0)
            check($sformatf("row%0d move_ticks", k), seen, vecs[k].ticks);
      end

      // reset landing on a move edge with grow and direction active
      do_reset();
      direction = 4'b0100; cycles(1);
      direction = 4'b1111; cycles(3);
      reset = 1'b0; direction = 4'b0100; grow = 1'b1;
      cycles(1);
      reset = 1'b1; grow = 1'b0; direction = 4'b1111;
      check_reset_state("reset-in-run");
      seen = 0;
      cycles(8);
      check("idle-after-reset head_x", head_x, 4);
      check("idle-after-reset ticks", seen, 0);
      direction = 4'b0100; cycles(1);
      direction = 4'b1111; cycles(4);
      check("no-stale-grow head_x", head_x, 5);
      check("no-stale-grow length", length, 3);

      // reset out of DEAD
      do_reset();
      direction = 4'b1000; cycles(1);
      direction = 4'b1111; cycles(4);
      check("dead-before-reset game_over", game_over, 1);
      reset = 1'b0; cycles(1);
      reset = 1'b1;
      check_reset_state("reset-in-dead");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
